swp_mem_responder: RTL

- Clocked memory-side responder for the load/store path of the pipelined core.
- Services single-word read, write and atomic swap (SWP) requests from the memory-stage initiator over a valid/ready request channel and a valid/ready response channel.
- Swap is performed as an indivisible read-then-write sequence; no other request can interleave.
- Backed by an internal word-addressed storage array.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_array_sp.sv | 23 ++
 rtl/swp_mem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared op encodings, FSM states and default widths for the SWP memory responder.
package mem_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_SWP = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        SWP_RD,
        SWP_WR,
        RESP
    } state_e;
endpackage

// File: rtl/mem_array_sp.sv
// Single-port word array: synchronous write, combinational read of the same index.
module mem_array_sp
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/swp_mem_responder.sv
// Memory-side responder servicing read, write and atomic swap over valid/ready channels.
module swp_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              accept;
    logic              req_err;
    op_e               req_op_e;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    assign req_op_e = op_e'(req_op);
    assign accept   = req_valid && (state_q == IDLE);
    assign req_err  = addr_err(req_addr) || (req_op_e == OP_RSV);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d   = req_err;
                    idx_d   = req_addr[ADDR_W+1:2];
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        case (req_op_e)
                            OP_RD:   state_d = RD;
                            OP_WR:   state_d = WR;
                            OP_SWP:  state_d = SWP_RD;
                            default: state_d = RESP;
                        endcase
                    end
                end
            end
            RD: begin
                rdata_d = mem_rdata;
                state_d = RESP;
            end
            WR: begin
                mem_we  = 1'b1;
                rdata_d = '0;
                state_d = RESP;
            end
            SWP_RD: begin
                rdata_d = mem_rdata;
                state_d = SWP_WR;
            end
            SWP_WR: begin
                mem_we  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Datapath registers carry no reset; the outputs are gated by state instead.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    mem_array_sp #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk_i  (clk),
        .we_i   (mem_we),
        .idx_i  (idx_q),
        .wdata_i(wdata_q),
        .rdata_o(mem_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign rsp_err   = (state_q == RESP) ? err_q : 1'b0;
endmodule
